// File: rtl/lap_stopwatch_core.sv
// lap_stopwatch_core: up/down centisecond stopwatch with preset load, done pulse
// and a lap-capture FIFO feeding the display or a host.
module lap_stopwatch_core #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int MAX_MIN   = 59,
    parameter int LAP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_edge,
    input  logic                       reset_edge,
    input  logic                       lap_edge,
    input  logic                       load_edge,
    input  logic                       mode_down,
    input  logic [5:0]                 preset_min,
    input  logic [5:0]                 preset_sec,
    output logic                       running,
    output logic [6:0]                 centiseconds,
    output logic [5:0]                 seconds,
    output logic [5:0]                 minutes,
    output logic                       done,
    input  logic                       lap_rd,
    output logic                       lap_valid,
    output logic [18:0]                lap_data,
    output logic [$clog2(LAP_DEPTH):0] lap_count,
    output logic                       lap_overflow
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic          down;
    logic [PW-1:0] presc;
    logic          tick;
    logic          c_top, s_top, m_top, c_bot, s_bot, m_bot, is_zero, dn_zero;
    logic [6:0]    cs_up, cs_dn;
    logic [5:0]    sec_up, sec_dn, min_up, min_dn, pre_min, pre_sec;

    assign tick    = state == RUN && presc == PW'(DIV - 1);
    assign c_top   = centiseconds == 7'd99;
    assign s_top   = seconds == 6'd59;
    assign m_top   = minutes == 6'(MAX_MIN);
    assign c_bot   = centiseconds == 7'd0;
    assign s_bot   = seconds == 6'd0;
    assign m_bot   = minutes == 6'd0;
    assign is_zero = c_bot && s_bot && m_bot;
    assign cs_up   = c_top ? 7'd0 : centiseconds + 7'd1;
    assign sec_up  = c_top ? (s_top ? 6'd0 : seconds + 6'd1) : seconds;
    assign min_up  = c_top && s_top ? (m_top ? 6'd0 : minutes + 6'd1) : minutes;
    assign cs_dn   = c_bot ? 7'd99 : centiseconds - 7'd1;
    assign sec_dn  = c_bot ? (s_bot ? 6'd59 : seconds - 6'd1) : seconds;
    assign min_dn  = c_bot && s_bot ? (m_bot ? 6'(MAX_MIN) : minutes - 6'd1) : minutes;
    // Only 00:00.01 borrows down to all-zero
    assign dn_zero = m_bot && s_bot && centiseconds == 7'd1;
    assign pre_min = preset_min > 6'(MAX_MIN) ? 6'(MAX_MIN) : preset_min;
    assign pre_sec = preset_sec > 6'd59 ? 6'd59 : preset_sec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            running      <= 1'b0;
            down         <= 1'b0;
            presc        <= '0;
            done         <= 1'b0;
            centiseconds <= 7'd0;
            seconds      <= 6'd0;
            minutes      <= 6'd0;
        end else begin
            done <= 1'b0;
            if (reset_edge) begin
                state        <= IDLE;
                running      <= 1'b0;
                presc        <= '0;
                centiseconds <= 7'd0;
                seconds      <= 6'd0;
                minutes      <= 6'd0;
            end else if (state == RUN) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    centiseconds <= down ? cs_dn : cs_up;
                    seconds      <= down ? sec_dn : sec_up;
                    minutes      <= down ? min_dn : min_up;
                end
                if (tick && down && dn_zero) begin
                    state   <= DONE;
                    running <= 1'b0;
                    done    <= 1'b1;
                end else if (start_edge) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            end else if (load_edge) begin
                state        <= IDLE;
                presc        <= '0;
                centiseconds <= 7'd0;
                seconds      <= pre_sec;
                minutes      <= pre_min;
            end else if (start_edge && state != DONE && !(mode_down && is_zero)) begin
                state   <= RUN;
                running <= 1'b1;
                down    <= mode_down;
            end
        end
    end

    logic [18:0]   mem [LAP_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_n;
    logic [CW-1:0] left, cnt_n;
    logic [18:0]   cur, head_n;
    logic          pop, lap_ok, full, push;

    assign cur    = {minutes, seconds, centiseconds};
    assign pop    = lap_rd && lap_count != '0;
    assign lap_ok = lap_edge && (state == RUN || state == PAUSE);
    assign full   = lap_count == CW'(LAP_DEPTH);
    assign push   = lap_ok && (!full || pop);
    assign left   = lap_count - CW'(pop);
    assign cnt_n  = left + CW'(push);
    assign rd_n   = rd_ptr + AW'(pop);
    // A push into an otherwise empty FIFO becomes the head before it lands in mem
    assign head_n = cnt_n == '0 ? 19'd0 : (left == '0 ? cur : mem[rd_n]);

    always_ff @(posedge clk) begin
        if (push && !reset_edge)
            mem[wr_ptr] <= cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            lap_count    <= '0;
            lap_valid    <= 1'b0;
            lap_data     <= 19'd0;
            lap_overflow <= 1'b0;
        end else if (reset_edge) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            lap_count    <= '0;
            lap_valid    <= 1'b0;
            lap_data     <= 19'd0;
            lap_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_n;
            lap_count <= cnt_n;
            lap_valid <= cnt_n != '0;
            lap_data  <= head_n;
            if (lap_ok && full && !pop)
                lap_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lap_stopwatch_core.sv
// tb_lap_stopwatch_core: directed and random stimulus checked every cycle against
// a model holding time as a single centisecond count and the laps in a queue.
module tb_lap_stopwatch_core;
    localparam int CLK_HZ = 1000;
    localparam int TICK_HZ = 100;
    localparam int MAX_MIN = 1;
    localparam int LAP_DEPTH = 4;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int TOT = (MAX_MIN + 1) * 6000;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start_edge = 1'b0, reset_edge = 1'b0, lap_edge = 1'b0, load_edge = 1'b0;
    logic mode_down = 1'b0, lap_rd = 1'b0;
    logic [5:0] preset_min = 6'd0, preset_sec = 6'd0;
    logic running, done, lap_valid, lap_overflow;
    logic [6:0] centiseconds;
    logic [5:0] seconds, minutes;
    logic [18:0] lap_data;
    logic [2:0] lap_count;

    lap_stopwatch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN), .LAP_DEPTH(LAP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start_edge(start_edge), .reset_edge(reset_edge),
        .lap_edge(lap_edge), .load_edge(load_edge), .mode_down(mode_down),
        .preset_min(preset_min), .preset_sec(preset_sec), .running(running),
        .centiseconds(centiseconds), .seconds(seconds), .minutes(minutes), .done(done),
        .lap_rd(lap_rd), .lap_valid(lap_valid), .lap_data(lap_data),
        .lap_count(lap_count), .lap_overflow(lap_overflow)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int st = S_IDLE, t_cs = 0, ph = 0;
    bit dn = 0, m_done = 0, m_ovf = 0, any_done = 0;
    logic [18:0] q[$];
    logic [18:0] laps[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] enc(input int v);
        return {6'(v / 6000), 6'((v / 100) % 60), 7'(v % 100)};
    endfunction

    function automatic int clampv(input int v, input int hi);
        return v > hi ? hi : v;
    endfunction

    task automatic model_reset();
        st = S_IDLE; t_cs = 0; ph = 0; dn = 0; m_done = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic mstep();
        bit stopped;
        m_done = 0;
        if (reset_edge) begin
            st = S_IDLE; t_cs = 0; ph = 0; m_ovf = 0;
            q.delete();
            return;
        end
        if (lap_rd && q.size() > 0) void'(q.pop_front());
        if (lap_edge && (st == S_RUN || st == S_PAUSE)) begin
            if (q.size() < LAP_DEPTH) q.push_back(enc(t_cs));
            else m_ovf = 1;
        end
        if (st == S_RUN) begin
            stopped = 0;
            ph++;
            if (ph == DIV) begin
                ph = 0;
                t_cs = dn ? t_cs - 1 : (t_cs + 1) % TOT;
                if (dn && t_cs == 0) begin
                    st = S_DONE; m_done = 1; stopped = 1;
                end
            end
            if (!stopped && start_edge) st = S_PAUSE;
        end else if (load_edge) begin
            st = S_IDLE; ph = 0;
            t_cs = clampv(int'(preset_min), MAX_MIN) * 6000 + clampv(int'(preset_sec), 59) * 100;
        end else if (start_edge && st != S_DONE && !(mode_down && t_cs == 0)) begin
            st = S_RUN; dn = mode_down;
        end
    endtask

    task automatic step();
        @(posedge clk);
        mstep();
        #1;
        chk("time", 32'({minutes, seconds, centiseconds}), 32'(enc(t_cs)));
        chk("run_done", 32'({running, done}), 32'({st == S_RUN, m_done}));
        chk("lap_stat", 32'({lap_valid, lap_count, lap_overflow}), 32'({q.size() > 0, 3'(q.size()), m_ovf}));
        chk("lap_data", 32'(lap_data), 32'(q.size() > 0 ? q[0] : 19'd0));
        if (done) any_done = 1;
        {reset_edge, load_edge, start_edge, lap_edge, lap_rd} = 5'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #12;
        chk("rst_time", 32'({minutes, seconds, centiseconds}), 32'd0);
        chk("rst_ctl", 32'({running, done, lap_valid, lap_count, lap_overflow}), 32'd0);
        chk("rst_lapdata", 32'(lap_data), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        steps(2);

        start_edge = 1'b1; step();
        chk("start_run", 32'(running), 32'd1);
        steps(1000);
        chk("one_second", 32'({minutes, seconds, centiseconds}), 32'({6'd0, 6'd1, 7'd0}));
        chk("still_run", 32'(running), 32'd1);

        for (int i = 0; i < 5; i++) begin
            laps[i] = enc(t_cs);
            lap_edge = 1'b1; step();
            steps(13 + i * 7);
        end
        chk("lap_full", 32'(lap_count), 32'd4);
        chk("lap_ovf", 32'(lap_overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("lap_pop", 32'(lap_data), 32'(laps[i]));
            lap_rd = 1'b1; step();
        end
        chk("lap_empty", 32'({lap_valid, lap_count}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            lap_edge = 1'b1; step(); steps(3);
        end
        lap_edge = 1'b1; lap_rd = 1'b1; step();
        chk("lap_both_cnt", 32'(lap_count), 32'd4);
        chk("lap_both_ovf", 32'(lap_overflow), 32'd1);

        reset_edge = 1'b1; load_edge = 1'b1; start_edge = 1'b1; lap_edge = 1'b1;
        preset_min = 6'd1; preset_sec = 6'd5; step();
        chk("all_ev_time", 32'({minutes, seconds, centiseconds}), 32'd0);
        chk("all_ev_ctl", 32'({running, lap_valid, lap_count, lap_overflow}), 32'd0);

        preset_min = 6'd63; preset_sec = 6'd63; load_edge = 1'b1; step();
        chk("clamp", 32'({minutes, seconds, centiseconds}), 32'({6'd1, 6'd59, 7'd0}));
        mode_down = 1'b0; any_done = 0;
        start_edge = 1'b1; step();
        steps(1000);
        chk("wrap_time", 32'({minutes, seconds, centiseconds}), 32'd0);
        chk("wrap_run", 32'(running), 32'd1);
        chk("wrap_nodone", 32'(any_done), 32'd0);

        reset_edge = 1'b1; step();
        mode_down = 1'b1; preset_min = 6'd0; preset_sec = 6'd1; load_edge = 1'b1; step();
        start_edge = 1'b1; step();
        steps(999);
        chk("cd_pre", 32'({running, done, minutes, seconds, centiseconds}), 32'({1'b1, 1'b0, 6'd0, 6'd0, 7'd1}));
        step();
        chk("cd_zero", 32'({running, done, minutes, seconds, centiseconds}), 32'({1'b0, 1'b1, 19'd0}));
        step();
        chk("cd_pulse_end", 32'(done), 32'd0);
        start_edge = 1'b1; step(); steps(20);
        chk("cd_ignore", 32'({running, centiseconds}), 32'd0);
        start_edge = 1'b1; step();
        chk("zero_nostart", 32'(running), 32'd0);

        reset_edge = 1'b1; step();
        mode_down = 1'b0; start_edge = 1'b1; step();
        steps(4);
        start_edge = 1'b1; step();
        chk("paused", 32'(running), 32'd0);
        steps(50);
        chk("pause_hold", 32'(centiseconds), 32'd0);
        start_edge = 1'b1; step();
        steps(4);
        chk("resume_pre", 32'(centiseconds), 32'd0);
        step();
        chk("resume_tick", 32'(centiseconds), 32'd1);

        for (int i = 0; i < 6000; i++) begin
            reset_edge = $urandom_range(0, 299) == 0;
            load_edge = $urandom_range(0, 59) == 0;
            start_edge = $urandom_range(0, 39) == 0;
            lap_edge = $urandom_range(0, 14) == 0;
            lap_rd = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 49) == 0) mode_down = ~mode_down;
            preset_min = 6'($urandom_range(0, 63));
            preset_sec = 6'($urandom_range(0, 3));
            step();
            if (i == 3000) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst", 32'({running, done, lap_valid, lap_count, lap_overflow, minutes, seconds, centiseconds}), 32'd0);
                chk("async_rst_lap", 32'(lap_data), 32'd0);
                model_reset();
                {reset_edge, load_edge, start_edge, lap_edge, lap_rd} = 5'b0;
                @(negedge clk) rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lap_stopwatch_core.md
# lap_stopwatch_core

Parametrised successor to the stopwatch counter: an up/down timing core with configurable tick rate, minute range and a lap-capture FIFO. It sits between the button debouncers (consuming their single-cycle edge pulses) and the seven-segment display (driving minutes/seconds/centiseconds). Adds countdown mode with preset load, a timeout pulse and a lap FIFO read by the display or a host.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 100, count rate (centisecond tick); DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2
- MAX_MIN, 59, highest minute value (≤ 63)
- LAP_DEPTH, 4, lap FIFO entries (power of two, ≥ 2)
- clk  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start_edge  in  1  one-cycle pulse: start/pause toggle
- reset_edge  in  1  one-cycle pulse: clear time and laps
- lap_edge  in  1  one-cycle pulse: capture current time
- load_edge  in  1  one-cycle pulse: load preset
- mode_down  in  1  0 = count up, 1 = count down; latched on entry to RUN
- preset_min  in  6  preset minutes (values > MAX_MIN clamp to MAX_MIN)
- preset_sec  in  6  preset seconds (values > 59 clamp to 59)
- running  out  1  1 while in RUN
- centiseconds  out  7  0..99
- seconds  out  6  0..59
- minutes  out  6  0..MAX_MIN
- done  out  1  one-cycle pulse when countdown reaches 00:00.00
- lap_rd  in  1  pop head of lap FIFO (ignored when empty)
- lap_valid  out  1  FIFO not empty
- lap_data  out  19  head entry {minutes, seconds, centiseconds}
- lap_count  out  $clog2(LAP_DEPTH)+1  entries held
- lap_overflow  out  1  sticky: a lap was dropped because FIFO full

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE.
- Event priority per cycle: reset_edge > load_edge > start_edge. lap_edge and lap_rd evaluated independently except reset_edge clears FIFO and wins over both.
- reset_edge (any state): time = 00:00.00, prescaler = 0, FIFO emptied, lap_overflow = 0, state IDLE.
- load_edge in IDLE/PAUSE/DONE: time = clamped preset, centiseconds = 0, prescaler = 0, state IDLE. Ignored in RUN.
- start_edge: IDLE/PAUSE → RUN (mode_down latched); RUN → PAUSE; DONE → ignored. IDLE/PAUSE with mode_down = 1 and time 00:00.00 → stays put.
- Prescaler counts 0..DIV-1 in RUN only; holds in PAUSE (resume continues mid-tick). Terminal count produces tick.
- Up tick: cs+1; 99 → 0 carry to sec; 59 → 0 carry to min; MAX_MIN:59.99 wraps to 00:00.00 and keeps running.
- Down tick: borrow chain mirrors up; tick taking time to 00:00.00 → state DONE, running = 0, done = 1 for that cycle.
- lap_edge in RUN or PAUSE: push current displayed time. Full: entry dropped, lap_overflow set. Full with lap_rd same cycle: pop and push both occur, no overflow. lap_edge in IDLE/DONE ignored.
- lap_rd when lap_valid: head advances; lap_data updates next cycle.

## Timing
- Reset values: running 0, time 00:00.00, done 0, lap_valid 0, lap_count 0, lap_overflow 0, lap_data 0.
- All outputs registered. start_edge at cycle t → running = 1 at t+1; first time change visible at t+DIV+1.
- Tick, carry and done land in one cycle (no multi-cycle carry ripple visible).
- Lap capture latency: push at cycle t → lap_valid/lap_count reflect at t+1; captured value equals time output at cycle t.
- Tick and lap_edge same cycle: lap stores pre-tick value.
- Asynchronous rst_n assertion mid-count forces all reset values immediately; release synchronous to clk.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (DIV=10): start, run 1000 cycles → 00:01.00 at cycle 1001 after start, running = 1.
- Up wrap, MAX_MIN=1: load preset 01:59, start, 100 ticks → 00:00.00, running stays 1, done never pulses.
- Countdown: mode_down=1, load 00:01, start → after 100 ticks time 00:00.00, done pulses exactly one cycle, running = 0; further start_edge ignored until load/reset.
- Pause/resume: start, pause at prescaler=4, wait 50 cycles, resume → next tick exactly 6 cycles after resume.
- Lap FIFO, LAP_DEPTH=4: 5 lap_edges in RUN → lap_count 4, lap_overflow 1, pops return first four times in order; full + lap_edge + lap_rd same cycle → count stays 4, overflow unchanged.
- Simultaneous reset_edge, load_edge, start_edge, lap_edge in RUN → IDLE, 00:00.00, FIFO empty, overflow 0.
